fifo_burst_reader: RTL
======================

# fifo_burst_reader

Single-clock consumer for the read port of `fifo_cdcc`. It drains words from the FIFO's valid/dready output stream and groups them into bursts of up to `INT_BURST_LEN` words. Each burst goes out on a downstream valid/ready stream as one header word followed by the buffered data words. A partial burst is flushed after an idle timeout. The block sits in the `rd_clk` domain between the FIFO and the packet/DMA logic.

## Interface
- `INT_DATA_WIDTH`, 32: word width; must be ≥ 32.
- `INT_BURST_LEN`, 16: maximum data words per burst, ≥ 2.
- `INT_TIMEOUT_CYCLES`, 64: idle cycles before a partial burst is flushed, ≥ 2.

- `rd_clk` in 1: the only clock.
- `rd_rst` in 1: synchronous, active-high reset.
- `i_data` in `INT_DATA_WIDTH`: FIFO read data.
- `i_data_valid` in 1: FIFO read data valid.
- `o_dready` out 1: ready to the FIFO; a word is taken when `i_data_valid && o_dready`.
- `o_data` out `INT_DATA_WIDTH`: downstream word.
- `o_valid` out 1: downstream valid.
- `i_ready` in 1: downstream ready; a beat transfers when `o_valid && i_ready`.
- `o_last` out 1: marks the final beat of a burst.
- `o_idle` out 1: high in `S_COLLECT` with an empty buffer.

## Operation
- Internal buffer: `INT_BURST_LEN` words, plus word count `cnt`, 16-bit sequence number `seq`, timeout counter `tmr`.
- State `S_COLLECT`:
  - `o_dready = 1` while `cnt < INT_BURST_LEN`; each accepted word goes to `buf[cnt]`, `cnt++`, `tmr` cleared.
  - `tmr` increments on each cycle with `cnt > 0` and no accept.
  - Go to `S_HEADER` when `cnt` reaches `INT_BURST_LEN`, or when `tmr` reaches `INT_TIMEOUT_CYCLES` with `cnt > 0`.
  - With `cnt == 0` the block waits indefinitely.
- State `S_HEADER`:
  - `o_valid = 1`, `o_data = {seq[15:0], zero pad, cnt[15:0]}`: seq in the top 16 bits, count in the low 16 bits.
  - On transfer, go to `S_DATA` with index `idx = 0`.
- State `S_DATA`:
  - `o_data = buf[idx]`, `o_valid = 1`; `idx++` on each transfer.
  - `o_last = 1` when `idx == cnt-1`.
  - On the last transfer: return to `S_COLLECT`, clear `cnt`, `seq++`.
- `o_dready = 0` in every state except `S_COLLECT`; the FIFO holds data meanwhile.
- `seq` wraps 0xFFFF→0x0000.
- Reset mid-burst: buffered words are discarded, and `seq`, `cnt`, `tmr`, `idx` return to 0.
- Outputs are decoded from registers only; there is no combinational path from `i_ready` or `i_data_valid` to any output.
- `o_valid` is never deasserted without a transfer.

## Timing
- Reset values: `o_dready = 1`, `o_valid = 0`, `o_last = 0`, `o_idle = 1`, `o_data = 0`, state `S_COLLECT`.
- Full burst: header `o_valid` is high in the cycle after the edge that accepted word `INT_BURST_LEN`.
- Timeout: header `o_valid` rises exactly `INT_TIMEOUT_CYCLES` cycles after the edge that accepted the last word.
- An accept in the same cycle the timer would expire clears the timer; no flush occurs that cycle.
- With `i_ready` held high, a burst drains at one beat per cycle: header + `cnt` beats.
- `o_dready` rises in the cycle after the last downstream transfer.
- `i_data` is ignored whenever `o_dready = 0`.

## Configuration
- `FIFO_BURST_READER_CHECKSUM_EN` defined:
  - A state `S_TRAILER` follows `S_DATA`, emitting one extra word: the XOR of all data words in the burst.
  - `o_last` moves from the final data word to the trailer.
  - The header count still counts data words only.
- Undefined: no trailer; `o_last` is on the final data word.

## Test plan
- Reset, then 16 words 1..16 with `i_ready = 1` → header 0x0000_0010, then data 1..16, `o_last` on 16, `o_dready = 0` for 17 cycles.
- 5 words, then idle → header `cnt = 5` exactly 64 cycles after the 5th accept; `seq = 1` if it follows the previous burst.
- Downstream `i_ready` toggling 1/0 each cycle over a 16-word burst → no beat lost or duplicated; `o_data` and `o_last` stable while stalled.
- `i_data_valid` held high with 40 words in the FIFO → bursts of 16, 16, 8; seq 0, 1, 2; the 8-word burst is flushed by timeout.
- `rd_rst` pulsed during `S_DATA` at `idx = 7` → outputs reach reset values next cycle; the following burst carries `seq = 0`.
- `FIFO_BURST_READER_CHECKSUM_EN` with words 1..16 → trailer 0x0000_0010 (XOR of 1..16 = 16) carries `o_last`.

Source files
------------

// File: rtl/fifo_burst_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader_if
//  Description : Handshake bundle for fifo_burst_reader. It carries the FIFO
//                read side (i_data / i_data_valid / o_dready) and the
//                downstream burst stream (o_data / o_valid / i_ready /
//                o_last), plus the o_idle status flag.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fifo_burst_reader_if #(
    parameter int INT_DATA_WIDTH = 32
) ();
    logic [INT_DATA_WIDTH-1:0] i_data;
    logic                      i_data_valid;
    logic                      o_dready;
    logic [INT_DATA_WIDTH-1:0] o_data;
    logic                      o_valid;
    logic                      i_ready;
    logic                      o_last;
    logic                      o_idle;

    // Environment side: feeds FIFO words and downstream ready
    modport master (
        output i_data, i_data_valid, i_ready,
        input  o_dready, o_data, o_valid, o_last, o_idle
    );

    // Burst reader side
    modport slave (
        input  i_data, i_data_valid, i_ready,
        output o_dready, o_data, o_valid, o_last, o_idle
    );
endinterface
`default_nettype wire

// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_burst_reader
//  Description : Drains the read port of fifo_cdcc and regroups the words
//                into bursts of up to INT_BURST_LEN words. Each burst is sent
//                downstream as a header {seq, pad, count} followed by the
//                buffered words. A partial burst is flushed after
//                INT_TIMEOUT_CYCLES idle cycles.
//                Optional macro FIFO_BURST_READER_CHECKSUM_EN appends an XOR
//                trailer word to every burst and moves o_last onto it.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int INT_DATA_WIDTH     = 32,
    parameter int INT_BURST_LEN      = 16,
    parameter int INT_TIMEOUT_CYCLES = 64
) (
    input  wire logic          rd_clk,
    input  wire logic          rd_rst,
    fifo_burst_reader_if.slave bus
);

    localparam int c_CNT_W = $clog2(INT_BURST_LEN + 1);
    localparam int c_IDX_W = $clog2(INT_BURST_LEN);
    localparam int c_TMR_W = $clog2(INT_TIMEOUT_CYCLES + 1);

    localparam logic [c_CNT_W-1:0] c_LEN      = c_CNT_W'(INT_BURST_LEN);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(INT_TIMEOUT_CYCLES - 1);

    localparam logic [1:0] S_COLLECT = 2'd0;
    localparam logic [1:0] S_HEADER  = 2'd1;
    localparam logic [1:0] S_DATA    = 2'd2;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    localparam logic [1:0] S_TRAILER = 2'd3;
`endif

    logic [1:0]                state_q, state_d;
    logic [c_CNT_W-1:0]        cnt_q,   cnt_d;
    logic [c_CNT_W-1:0]        idx_q,   idx_d;
    logic [c_TMR_W-1:0]        tmr_q,   tmr_d;
    logic [15:0]               seq_q,   seq_d;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
    logic [INT_DATA_WIDTH-1:0] csum_q,  csum_d;
`endif
    logic [INT_DATA_WIDTH-1:0] mem_q [INT_BURST_LEN];

    logic                      w_dready;
    logic                      w_take;
    logic                      w_at_last;
    logic [INT_DATA_WIDTH-1:0] w_header;
    logic [INT_DATA_WIDTH-1:0] w_data;
    logic                      w_valid;
    logic                      w_last;

    // Only collect while there is room; the FIFO holds its word otherwise
    assign w_dready  = (state_q == S_COLLECT) && (cnt_q < c_LEN);
    assign w_take    = bus.i_data_valid && w_dready;
    assign w_at_last = (idx_q == (cnt_q - c_CNT_W'(1)));

    // Header word: sequence number on top, data-word count at the bottom
    always_comb begin
        w_header                            = '0;
        w_header[INT_DATA_WIDTH-1 -: 16]    = seq_q;
        w_header[15:0]                      = 16'(cnt_q);
    end

    // Next-state logic for the collect / header / data (/ trailer) sequencer
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        tmr_d   = tmr_q;
        seq_d   = seq_q;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            S_COLLECT: begin
                if (w_take) begin
                    // An accept always restarts the idle timer, even on the
                    // cycle the timer would otherwise have expired.
                    cnt_d = cnt_q + c_CNT_W'(1);
                    tmr_d = '0;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
                    csum_d = csum_q ^ bus.i_data;
`endif
                    if (cnt_q == c_LEN - c_CNT_W'(1)) begin
                        state_d = S_HEADER;
                    end
                end else if (cnt_q != '0) begin
                    // Flush lands exactly INT_TIMEOUT_CYCLES edges after the last accept
                    tmr_d = tmr_q + c_TMR_W'(1);
                    if (tmr_q == c_TMR_LAST) begin
                        state_d = S_HEADER;
                    end
                end
            end
            S_HEADER: begin
                if (bus.i_ready) begin
                    state_d = S_DATA;
                    idx_d   = '0;
                end
            end
            S_DATA: begin
                if (bus.i_ready) begin
                    if (w_at_last) begin
`ifdef FIFO_BURST_READER_CHECKSUM_EN
                        state_d = S_TRAILER;
`else
                        state_d = S_COLLECT;
                        cnt_d   = '0;
                        tmr_d   = '0;
                        seq_d   = seq_q + 16'd1;
`endif
                    end else begin
                        idx_d = idx_q + c_CNT_W'(1);
                    end
                end
            end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            S_TRAILER: begin
                if (bus.i_ready) begin
                    state_d = S_COLLECT;
                    cnt_d   = '0;
                    tmr_d   = '0;
                    seq_d   = seq_q + 16'd1;
                    csum_d  = '0;
                end
            end
`endif
            default: begin
                state_d = S_COLLECT;
            end
        endcase
    end

    // Sequencer registers with synchronous reset; a reset discards any burst
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            state_q <= S_COLLECT;
            cnt_q   <= '0;
            idx_q   <= '0;
            tmr_q   <= '0;
            seq_q   <= '0;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            tmr_q   <= tmr_d;
            seq_q   <= seq_d;
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    // Burst buffer write; contents are don't-care until cnt covers them
    always_ff @(posedge rd_clk) begin
        if (w_take) begin
            mem_q[cnt_q[c_IDX_W-1:0]] <= bus.i_data;
        end
    end

    // Output decode from registered state only (no path from i_ready/i_data_valid)
    always_comb begin
        w_data  = '0;
        w_valid = 1'b0;
        w_last  = 1'b0;
        case (state_q)
            S_HEADER: begin
                w_valid = 1'b1;
                w_data  = w_header;
            end
            S_DATA: begin
                w_valid = 1'b1;
                w_data  = mem_q[idx_q[c_IDX_W-1:0]];
`ifndef FIFO_BURST_READER_CHECKSUM_EN
                w_last  = w_at_last;
`endif
            end
`ifdef FIFO_BURST_READER_CHECKSUM_EN
            S_TRAILER: begin
                w_valid = 1'b1;
                w_data  = csum_q;
                w_last  = 1'b1;
            end
`endif
            default: begin
                w_valid = 1'b0;
            end
        endcase
    end

    assign bus.o_dready = w_dready;
    assign bus.o_data   = w_data;
    assign bus.o_valid  = w_valid;
    assign bus.o_last   = w_last;
    assign bus.o_idle   = (state_q == S_COLLECT) && (cnt_q == '0);

endmodule
`default_nettype wire
